tour_cmd_seq: RTL and testbench

Sequences a computed knight's tour into physical motion commands for cmd_proc. Once the tour solution is ready, it reads the 24 stored one-hot moves, indexed by mv_indx. Each move is issued as two commands: a vertical component, then a horizontal component with fanfare. When no tour is active, the block passes UART commands straight through, so it also acts as the command mux in front of cmd_proc. It also generates the response byte sent back over UART.

---
 rtl/tour_cmd_seq_if.sv | 43 ++++
 rtl/tour_cmd_seq.sv | 192 +++++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// tour_cmd_seq_if
// Bundles the tour sequencer's handshake and command signals.
//   slave  modport : used by tour_cmd_seq (the sequencer itself)
//   master modport : used by the surrounding logic / testbench
// Signals:
//   start_tour   : one-cycle pulse, tour solution ready
//   move         : one-hot move read from tour memory at mv_indx
//   mv_indx      : index of the current move
//   cmd_UART     : command from the UART wrapper
//   cmd_rdy_UART : UART command valid
//   cmd          : command presented to cmd_proc
//   cmd_rdy      : command valid to cmd_proc
//   clr_cmd_rdy  : cmd_proc has consumed cmd
//   send_resp    : cmd_proc finished the current command
//   resp         : response byte for the UART transmitter
//   tour_busy    : high while a tour is executing
//   tour_err     : one-cycle pulse on an illegal (zero) move
// ---------------------------------------------------------------------------
interface tour_cmd_seq_if;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        tour_busy;
  logic        tour_err;

  modport slave (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, cmd, cmd_rdy, resp, tour_busy, tour_err
  );

  modport master (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, cmd, cmd_rdy, resp, tour_busy, tour_err
  );
endinterface

// File: rtl/tour_cmd_seq.sv
// ---------------------------------------------------------------------------
// tour_cmd_seq
// Turns a stored knight's tour into motion commands for cmd_proc. Each move
// becomes a vertical plain-move command followed by a horizontal
// move-with-fanfare command. With no tour running, the UART command path is
// passed straight through, so this block is also the command mux in front of
// cmd_proc.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : tour_cmd_seq_if.slave (handshake, move fetch, command and response)
// ---------------------------------------------------------------------------
module tour_cmd_seq #(
  parameter int         NUM_MOVES   = 24,
  parameter logic [3:0] OPC_MOVE    = 4'h2,
  parameter logic [3:0] OPC_FANFARE = 4'h3
) (
  input  logic          clk,
  input  logic          rst,
  tour_cmd_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    HOLD_V = 3'd2,
    HORZ   = 3'd3,
    HOLD_H = 3'd4
  } state_t;

  localparam logic [7:0] HDG_N     = 8'h00;
  localparam logic [7:0] HDG_W     = 8'h3F;
  localparam logic [7:0] HDG_S     = 8'h7F;
  localparam logic [7:0] HDG_E     = 8'hBF;
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;
  localparam logic [4:0] LAST_IDX  = 5'(NUM_MOVES - 1);

  // Decodes a move into {vert heading, |dy|, horiz heading, |dx|}.
  // casez gives priority to the lowest set bit, so multi-hot moves resolve
  // to their lowest bit. A zero move decodes to all zeros.
  function automatic logic [23:0] decode_move(input logic [7:0] mv);
    logic [23:0] d;
    casez (mv)
      8'b???????1: d = {HDG_N, 4'd2, HDG_E, 4'd1};  // (+1,+2)
      8'b??????10: d = {HDG_N, 4'd2, HDG_W, 4'd1};  // (-1,+2)
      8'b?????100: d = {HDG_N, 4'd1, HDG_W, 4'd2};  // (-2,+1)
      8'b????1000: d = {HDG_S, 4'd1, HDG_W, 4'd2};  // (-2,-1)
      8'b???10000: d = {HDG_S, 4'd2, HDG_W, 4'd1};  // (-1,-2)
      8'b??100000: d = {HDG_S, 4'd2, HDG_E, 4'd1};  // (+1,-2)
      8'b?1000000: d = {HDG_S, 4'd1, HDG_E, 4'd2};  // (+2,-1)
      8'b10000000: d = {HDG_N, 4'd1, HDG_E, 4'd2};  // (+2,+1)
      default:     d = 24'h000000;
    endcase
    return d;
  endfunction

  state_t      r_state;
  logic [4:0]  r_mv_indx;
  logic        r_tour_busy;
  logic        r_tour_err;
  logic [15:0] r_cmd_hold;  // command captured at clr_cmd_rdy, shown in HOLD_*

  logic [23:0] w_dec;
  logic [15:0] w_vert_cmd;
  logic [15:0] w_horz_cmd;
  logic        w_move_zero;
  logic        w_last_move;
  logic [15:0] w_cmd;
  logic        w_cmd_rdy;
  logic [7:0]  w_resp;

  assign w_dec       = decode_move(bus.move);
  assign w_vert_cmd  = {OPC_MOVE, w_dec[23:12]};
  assign w_horz_cmd  = {OPC_FANFARE, w_dec[11:0]};
  assign w_move_zero = (bus.move == 8'h00);
  assign w_last_move = (r_mv_indx == LAST_IDX);

  // Tour sequencing FSM: walks VERT/HOLD_V/HORZ/HOLD_H once per move.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mv_indx   <= 5'd0;
      r_tour_busy <= 1'b0;
      r_tour_err  <= 1'b0;
      r_cmd_hold  <= 16'h0000;
    end else begin
      r_tour_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_tour) begin
            r_state     <= VERT;
            r_mv_indx   <= 5'd0;
            r_tour_busy <= 1'b1;
          end
        end
        VERT: begin
          // An empty move slot means the stored tour is broken: abort.
          if (w_move_zero) begin
            r_state     <= IDLE;
            r_mv_indx   <= 5'd0;
            r_tour_busy <= 1'b0;
            r_tour_err  <= 1'b1;
          end else if (bus.clr_cmd_rdy) begin
            r_cmd_hold <= w_vert_cmd;
            r_state    <= HOLD_V;
          end
        end
        HOLD_V: begin
          if (bus.send_resp) begin
            r_state <= HORZ;
          end
        end
        HORZ: begin
          if (bus.clr_cmd_rdy) begin
            r_cmd_hold <= w_horz_cmd;
            r_state    <= HOLD_H;
          end
        end
        HOLD_H: begin
          if (bus.send_resp) begin
            if (w_last_move) begin
              r_state     <= IDLE;
              r_mv_indx   <= 5'd0;
              r_tour_busy <= 1'b0;
            end else begin
              r_state   <= VERT;
              r_mv_indx <= r_mv_indx + 5'd1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mv_indx   <= 5'd0;
          r_tour_busy <= 1'b0;
        end
      endcase
    end
  end

  // Command mux and response byte. Kept combinational so the UART path is
  // transparent in IDLE and resp is valid in the same cycle as send_resp.
  always_comb begin
    w_cmd     = bus.cmd_UART;
    w_cmd_rdy = bus.cmd_rdy_UART;
    w_resp    = RESP_DONE;
    case (r_state)
      IDLE: begin
        w_cmd     = bus.cmd_UART;
        w_cmd_rdy = bus.cmd_rdy_UART;
        w_resp    = RESP_DONE;
      end
      VERT: begin
        w_cmd     = w_vert_cmd;
        w_cmd_rdy = ~w_move_zero;
        w_resp    = RESP_DONE;
      end
      HOLD_V: begin
        w_cmd     = r_cmd_hold;
        w_cmd_rdy = 1'b0;
        w_resp    = RESP_ACK;
      end
      HORZ: begin
        w_cmd     = w_horz_cmd;
        w_cmd_rdy = 1'b1;
        w_resp    = RESP_DONE;
      end
      HOLD_H: begin
        w_cmd     = r_cmd_hold;
        w_cmd_rdy = 1'b0;
        if (w_last_move) begin
          w_resp = RESP_DONE;
        end else begin
          w_resp = RESP_ACK;
        end
      end
      default: begin
        w_cmd     = bus.cmd_UART;
        w_cmd_rdy = bus.cmd_rdy_UART;
        w_resp    = RESP_DONE;
      end
    endcase
  end

  assign bus.cmd       = w_cmd;
  assign bus.cmd_rdy   = w_cmd_rdy;
  assign bus.resp      = w_resp;
  assign bus.mv_indx   = r_mv_indx;
  assign bus.tour_busy = r_tour_busy;
  assign bus.tour_err  = r_tour_err;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_tour_cmd_seq
// Self-checking bench for tour_cmd_seq: constant vector tables for the UART
// passthrough and move decode, a knight-offset reference model for random
// tours, and hand sequences for zero moves and reset mid-tour.
// ---------------------------------------------------------------------------
module tb_tour_cmd_seq;
  localparam int NUM = 24;

  logic clk;
  logic rst;
  tour_cmd_seq_if bus();

  tour_cmd_seq dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tour memory model: move is read combinationally at the DUT's index.
  logic [7:0]  tour_mem [32];
  logic [15:0] exp_v [NUM];
  logic [15:0] exp_h [NUM];
  assign bus.move = tour_mem[bus.mv_indx];

  int n_pass  = 0;
  int n_total = 0;

  // Knight offsets per move bit.
  int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  typedef struct {
    logic [15:0] cu;
    logic        ru;
    logic [15:0] ec;
    logic        er;
  } idle_vec_t;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } dec_vec_t;

  idle_vec_t idle_tab [4];
  dec_vec_t  dec_tab  [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lowest set bit picks the knight offset; vertical is N/S by
  // sign of dy, horizontal is E/W by sign of dx, magnitude as squares.
  function automatic logic [15:0] ref_cmd(input logic [7:0] mv, input bit horiz);
    int b = 0;
    int d;
    int mag;
    logic [7:0] hd;
    for (int k = 7; k >= 0; k--) if (mv[k]) b = k;
    d   = horiz ? dx_tab[b] : dy_tab[b];
    mag = (d < 0) ? -d : d;
    if (horiz) hd = (d > 0) ? 8'hBF : 8'h3F;
    else       hd = (d > 0) ? 8'h00 : 8'h7F;
    return {(horiz ? 4'h3 : 4'h2), hd, mag[3:0]};
  endfunction

  // Random cycles of unrelated traffic while the tour waits; the tour-driven
  // outputs must not move.
  task automatic noise(input int n, input bit in_hold, input logic exp_rdy,
                       input logic [15:0] exp_cmd, input int idx);
    for (int k = 0; k < n; k++) begin
      bus.clr_cmd_rdy  = in_hold ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.send_resp    = in_hold ? 1'b0 : 1'($urandom_range(0, 1));
      bus.start_tour   = 1'($urandom_range(0, 1));
      bus.cmd_rdy_UART = 1'($urandom_range(0, 1));
      bus.cmd_UART     = 16'($urandom);
      tick();
      chk($sformatf("noise_rdy[%0d]", idx), 32'(bus.cmd_rdy), 32'(exp_rdy));
      chk($sformatf("noise_cmd[%0d]", idx), 32'(bus.cmd), 32'(exp_cmd));
      chk($sformatf("noise_idx[%0d]", idx), 32'(bus.mv_indx), 32'(idx));
    end
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;
    bus.start_tour   = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    bus.cmd_UART     = 16'h0000;
  endtask

  task automatic run_tour(input int abort_idx);
    bus.start_tour = 1'b1;
    tick();
    bus.start_tour = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      chk($sformatf("v_rdy[%0d]", i), 32'(bus.cmd_rdy), 32'd1);
      chk($sformatf("v_cmd[%0d]", i), 32'(bus.cmd), 32'(exp_v[i]));
      chk($sformatf("v_idx[%0d]", i), 32'(bus.mv_indx), 32'(i));
      chk($sformatf("v_busy[%0d]", i), 32'(bus.tour_busy), 32'd1);
      noise($urandom_range(0, 2), 1'b0, 1'b1, exp_v[i], i);
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.clr_cmd_rdy = 1'b0;
      chk($sformatf("hv_rdy[%0d]", i), 32'(bus.cmd_rdy), 32'd0);
      chk($sformatf("hv_cmd[%0d]", i), 32'(bus.cmd), 32'(exp_v[i]));
      chk($sformatf("hv_resp[%0d]", i), 32'(bus.resp), 32'h5A);
      noise($urandom_range(0, 2), 1'b1, 1'b0, exp_v[i], i);
      bus.send_resp = 1'b1;
      tick();
      bus.send_resp = 1'b0;
      chk($sformatf("h_rdy[%0d]", i), 32'(bus.cmd_rdy), 32'd1);
      chk($sformatf("h_cmd[%0d]", i), 32'(bus.cmd), 32'(exp_h[i]));
      noise($urandom_range(0, 2), 1'b0, 1'b1, exp_h[i], i);
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.clr_cmd_rdy = 1'b0;
      chk($sformatf("hh_rdy[%0d]", i), 32'(bus.cmd_rdy), 32'd0);
      chk($sformatf("hh_resp[%0d]", i), 32'(bus.resp), (i == NUM - 1) ? 32'hA5 : 32'h5A);
      if (i == abort_idx) begin
        rst = 1'b1;
        bus.cmd_rdy_UART = 1'b1;
        bus.cmd_UART = 16'h2023;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.tour_busy), 32'd0);
        chk("rst_idx", 32'(bus.mv_indx), 32'd0);
        chk("rst_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("rst_cmd", 32'(bus.cmd), 32'h2023);
        chk("rst_resp", 32'(bus.resp), 32'hA5);
        bus.cmd_rdy_UART = 1'b0;
        bus.cmd_UART = 16'h0000;
        return;
      end
      noise($urandom_range(0, 2), 1'b1, 1'b0, exp_h[i], i);
      bus.send_resp = 1'b1;
      tick();
      bus.send_resp = 1'b0;
    end
    chk("end_busy", 32'(bus.tour_busy), 32'd0);
    chk("end_idx", 32'(bus.mv_indx), 32'd0);
    chk("end_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("end_resp", 32'(bus.resp), 32'hA5);
  endtask

  task automatic load_random_tour();
    for (int i = 0; i < NUM; i++) begin
      if ($urandom_range(0, 1) == 0) tour_mem[i] = 8'(1 << $urandom_range(0, 7));
      else tour_mem[i] = 8'($urandom_range(1, 255));
      exp_v[i] = ref_cmd(tour_mem[i], 1'b0);
      exp_h[i] = ref_cmd(tour_mem[i], 1'b1);
    end
  endtask

  initial begin
    idle_tab[0] = '{16'h2023, 1'b1, 16'h2023, 1'b1};
    idle_tab[1] = '{16'h3BF1, 1'b0, 16'h3BF1, 1'b0};
    idle_tab[2] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    idle_tab[3] = '{16'h0000, 1'b0, 16'h0000, 1'b0};

    dec_tab[0] = '{8'h01, 16'h2002, 16'h3BF1};
    dec_tab[1] = '{8'h02, 16'h2002, 16'h33F1};
    dec_tab[2] = '{8'h04, 16'h2001, 16'h33F2};
    dec_tab[3] = '{8'h08, 16'h27F1, 16'h33F2};
    dec_tab[4] = '{8'h10, 16'h27F2, 16'h33F1};
    dec_tab[5] = '{8'h20, 16'h27F2, 16'h3BF1};
    dec_tab[6] = '{8'h40, 16'h27F1, 16'h3BF2};
    dec_tab[7] = '{8'h80, 16'h2001, 16'h3BF2};
    dec_tab[8] = '{8'h30, 16'h27F2, 16'h33F1};

    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h00;
    bus.start_tour   = 1'b0;
    bus.cmd_UART     = 16'h1234;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("reset_idx", 32'(bus.mv_indx), 32'd0);
    chk("reset_busy", 32'(bus.tour_busy), 32'd0);
    chk("reset_err", 32'(bus.tour_err), 32'd0);
    chk("reset_resp", 32'(bus.resp), 32'hA5);
    chk("reset_cmd", 32'(bus.cmd), 32'h1234);
    chk("reset_rdy", 32'(bus.cmd_rdy), 32'd0);
    rst = 1'b0;
    tick();

    // Idle passthrough table
    for (int i = 0; i < 4; i++) begin
      bus.cmd_UART     = idle_tab[i].cu;
      bus.cmd_rdy_UART = idle_tab[i].ru;
      #1;
      chk($sformatf("idle_cmd[%0d]", i), 32'(bus.cmd), 32'(idle_tab[i].ec));
      chk($sformatf("idle_rdy[%0d]", i), 32'(bus.cmd_rdy), 32'(idle_tab[i].er));
      chk($sformatf("idle_resp[%0d]", i), 32'(bus.resp), 32'hA5);
      tick();
    end
    bus.cmd_UART     = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;

    // Table-driven tour: cycles the nine decode vectors
    for (int i = 0; i < NUM; i++) begin
      tour_mem[i] = dec_tab[i % 9].mv;
      exp_v[i]    = dec_tab[i % 9].v;
      exp_h[i]    = dec_tab[i % 9].h;
    end
    run_tour(-1);
    tick();

    // Random tours against the reference model
    for (int t = 0; t < 2; t++) begin
      load_random_tour();
      run_tour(-1);
      tick();
    end

    // Reset in HOLD_H at mv_indx=7, then a clean tour afterwards
    load_random_tour();
    run_tour(7);
    tick();
    load_random_tour();
    run_tour(-1);
    tick();

    // Zero move: error pulse, back to IDLE, no cmd_rdy
    tour_mem[0] = 8'h00;
    bus.start_tour = 1'b1;
    tick();
    bus.start_tour = 1'b0;
    chk("zero_rdy", 32'(bus.cmd_rdy), 32'd0);
    tick();
    chk("zero_err", 32'(bus.tour_err), 32'd1);
    chk("zero_busy", 32'(bus.tour_busy), 32'd0);
    chk("zero_idx", 32'(bus.mv_indx), 32'd0);
    chk("zero_rdy_idle", 32'(bus.cmd_rdy), 32'd0);
    tick();
    chk("zero_err_pulse", 32'(bus.tour_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
